cordic_ctrl: RTL
================

# cordic_ctrl

Sequencer for the CORDIC angle-convergence loop. It owns the accumulated angle z and the iteration counter. Each iteration it presents z and the captured target to the registered magnitude comparator (Comp), waits for its lt/gt result, then issues a rotation step with direction to the x/y datapath. It sits between the top-level start/done interface and the Comp + arctan ROM + x/y shift-add datapath.

## Interface
- ITER, 6: iterations per run, 1..16
- DW, 6: angle width, matching comparator operand width
- AW, 4: arctan ROM address width, 2^AW ≥ ITER

- CLK  in  1  clock, all state on rising edge
- RST_n  in  1  asynchronous, active-low reset
- start  in  1  run request; honoured only in IDLE
- abort  in  1  synchronous cancel; honoured in any non-IDLE state
- target  in  DW  target angle; captured on accepted start
- atan_data  in  DW  arctan ROM word for mem_addr, combinational read, valid same cycle
- lt, gt  in  1  comparator outputs, registered one cycle after operands
- cmp_a  out  DW  comparator from_Mux operand = z
- cmp_b  out  DW  comparator from_Mem operand = captured target
- mem_addr  out  AW  arctan ROM index = current iteration
- step  out  1  one-cycle pulse: datapath performs one rotation
- dir  out  1  valid with step; 1 = subtract (z > target), 0 = add
- z_out  out  DW  accumulated angle
- busy  out  1  state ≠ IDLE
- done  out  1  one-cycle pulse at end of run
- cmp_err  out  1  sticky until next accepted start; set on an invalid comparator pair

## Operation
- States: IDLE, LOAD, CMP, DECIDE, DONE.
- IDLE → LOAD on start.
  - Capture target.
  - Clear cmp_err.
- LOAD → CMP.
  - z ← 0.
  - iter ← 0.
- CMP → DECIDE.
  - Operands cmp_a/cmp_b are stable; Comp latches them at the closing edge.
- DECIDE samples lt/gt:
  - gt=1, lt=0: step=1, dir=1, z ← z − atan_data.
  - lt=1, gt=0: step=1, dir=0, z ← z + atan_data.
  - lt==gt (00 or 11): no step; set cmp_err; go to DONE.
  - Valid pair with iter = ITER−1: go to DONE. Otherwise iter ← iter+1 and go to CMP.
- DONE → IDLE; done=1 for this one cycle.
- Arithmetic: z is unsigned DW bits, wraps modulo 2^DW, no saturation. Equality (z == target) yields dir=0.
- mem_addr = iter, zero-extended to AW. atan_data is used only in DECIDE.
- start outside IDLE is ignored, including in DONE.
- abort in LOAD/CMP/DECIDE/DONE: next state IDLE. No done pulse, no step that cycle; z_out holds.
- abort has priority over every other transition.

## Timing
- Reset values: state IDLE, z=0, iter=0, captured target=0, step=0, dir=0, busy=0, done=0, cmp_err=0.
- Outputs cmp_a/cmp_b/z_out/mem_addr follow the reset registers.
- Start accepted at edge 0:
  - Cycle 1: LOAD.
  - Iteration k (0-based): CMP in cycle 2+2k, DECIDE in cycle 3+2k.
  - DONE in cycle 2+2·ITER.
  - Total latency 2·ITER+2 cycles.
  - For ITER=6: done in cycle 14; busy high for cycles 1–14.
- step, dir, and the z update all occur in DECIDE only; z_out is updated at the edge closing DECIDE.
- Earliest next accepted start: the cycle after DONE (IDLE).
- RST_n low at any time clears everything immediately. No done pulse is generated. After release the block is in IDLE.

## Structure
- Package cordic_pkg holds:
  - State enum.
  - Default ITER/DW/AW.
  - dir encodings DIR_ADD=0, DIR_SUB=1.
- Single module; no sub-module required.
- The iteration counter stays inline, since its width is $clog2(ITER) and is trivial.

## Test plan
- Nominal run (ITER=6, DW=6; atan table 32,19,10,5,3,1; stub Comp with one-cycle registered compare; target=20; start pulse):
  - dir sequence 0,1,0,1,0,1.
  - z after each step: 32,13,23,18,21,20.
  - done in cycle 14, z_out=20, cmp_err=0.
- Equality (target=0): first compare has z=0=target → dir=0, z=32. Then the sequence continues per the comparator results.
- Invalid pair (bench forces lt=gt=1 in DECIDE of iteration 2):
  - Exactly 2 steps issued.
  - cmp_err=1, done pulse in the following cycle.
  - cmp_err clears on the next accepted start.
- Abort: assert abort in iteration 3's CMP → IDLE next cycle. No further step, no done, busy=0.
- Start while busy: start pulses in cycles 5 and 14 are ignored. A single done in cycle 14 and no second run.
- Async reset: drop RST_n in cycle 7 → all outputs at reset values within that cycle, no done. A new start after release runs the full 14-cycle sequence.

Source files
------------

// File: rtl/cordic_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cordic_pkg
// Description : Shared types and constants for the CORDIC angle sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package cordic_pkg;

  // Sequencer states
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_CMP    = 3'd2,
    ST_DECIDE = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  // Default geometry
  localparam int ITER_DEFAULT = 6;
  localparam int DW_DEFAULT   = 6;
  localparam int AW_DEFAULT   = 4;

  // Rotation direction encodings
  localparam logic DIR_ADD = 1'b0;
  localparam logic DIR_SUB = 1'b1;

endpackage : cordic_pkg
`default_nettype wire

// File: rtl/cordic_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : cordic_ctrl
// Description : Sequencer for the CORDIC angle-convergence loop. Owns the
//               accumulated angle z and the iteration counter, drives the
//               registered comparator and issues rotation steps.
// Revision    : 1.0 - initial release
// ============================================================================
module cordic_ctrl
  import cordic_pkg::*;
#(
  parameter int ITER = ITER_DEFAULT,
  parameter int DW   = DW_DEFAULT,
  parameter int AW   = AW_DEFAULT
) (
  input  logic          CLK,
  input  logic          RST_n,
  input  logic          start,
  input  logic          abort,
  input  logic [DW-1:0] target,
  input  logic [DW-1:0] atan_data,
  input  logic          lt,
  input  logic          gt,
  output logic [DW-1:0] cmp_a,
  output logic [DW-1:0] cmp_b,
  output logic [AW-1:0] mem_addr,
  output logic          step,
  output logic          dir,
  output logic [DW-1:0] z_out,
  output logic          busy,
  output logic          done,
  output logic          cmp_err
);

  // Counter width; a single-iteration build still needs one bit
  localparam int            IW     = (ITER > 1) ? $clog2(ITER) : 1;
  localparam logic [IW-1:0] C_LAST = IW'(ITER - 1);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [DW-1:0] r_z;
  logic [DW-1:0] w_z_nxt;
  logic [DW-1:0] r_target;
  logic [DW-1:0] w_target_nxt;
  logic [IW-1:0] r_iter;
  logic [IW-1:0] w_iter_nxt;
  logic          r_cmp_err;
  logic          w_cmp_err_nxt;
  logic          w_pair_ok;
  logic          w_step;
  logic          w_dir;
  logic          w_done;

  // Exactly one of lt/gt must be set for a usable comparator result
  assign w_pair_ok = lt ^ gt;

  // State and datapath registers
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      r_state   <= ST_IDLE;
      r_z       <= '0;
      r_target  <= '0;
      r_iter    <= '0;
      r_cmp_err <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_z       <= w_z_nxt;
      r_target  <= w_target_nxt;
      r_iter    <= w_iter_nxt;
      r_cmp_err <= w_cmp_err_nxt;
    end
  end

  // Next-state, register updates and pulse outputs; abort overrides all
  always_comb begin
    w_state_nxt   = r_state;
    w_z_nxt       = r_z;
    w_target_nxt  = r_target;
    w_iter_nxt    = r_iter;
    w_cmp_err_nxt = r_cmp_err;
    w_step        = 1'b0;
    w_dir         = DIR_ADD;
    w_done        = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nxt   = ST_LOAD;
          w_target_nxt  = target;
          w_cmp_err_nxt = 1'b0;
        end
      end
      ST_LOAD: begin
        w_state_nxt = ST_CMP;
        w_z_nxt     = '0;
        w_iter_nxt  = '0;
      end
      ST_CMP: begin
        // Operands held steady; comparator latches them at this edge
        w_state_nxt = ST_DECIDE;
      end
      ST_DECIDE: begin
        if (w_pair_ok) begin
          w_step  = 1'b1;
          w_dir   = gt ? DIR_SUB : DIR_ADD;
          w_z_nxt = gt ? (r_z - atan_data) : (r_z + atan_data);
          if (r_iter == C_LAST) begin
            w_state_nxt = ST_DONE;
          end else begin
            w_iter_nxt  = r_iter + 1'b1;
            w_state_nxt = ST_CMP;
          end
        end else begin
          w_cmp_err_nxt = 1'b1;
          w_state_nxt   = ST_DONE;
        end
      end
      ST_DONE: begin
        w_done      = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    // Cancel: back to IDLE with no step, no done and all registers held
    if (abort && (r_state != ST_IDLE)) begin
      w_state_nxt   = ST_IDLE;
      w_z_nxt       = r_z;
      w_target_nxt  = r_target;
      w_iter_nxt    = r_iter;
      w_cmp_err_nxt = r_cmp_err;
      w_step        = 1'b0;
      w_dir         = DIR_ADD;
      w_done        = 1'b0;
    end
  end

  assign cmp_a    = r_z;
  assign cmp_b    = r_target;
  assign mem_addr = AW'(r_iter);
  assign z_out    = r_z;
  assign step     = w_step;
  assign dir      = w_dir;
  assign done     = w_done;
  assign busy     = (r_state != ST_IDLE);
  assign cmp_err  = r_cmp_err;

endmodule : cordic_ctrl
`default_nettype wire
